// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus: PC/instruction path to memory and the IR
// valid/ack handshake to the decoder, plus jump and halt controls.
// The master side is the fetch unit; the slave side is memory/decoder/control.
`timescale 1ns/1ps
interface fetch_unit_if #(
  parameter int PC_W  = 4,
  parameter int INS_W = 9
);
  logic [PC_W-1:0]  pc;
  logic [INS_W-1:0] ins_in;
  logic [INS_W-1:0] ir;
  logic             ir_valid;
  logic             ir_ack;
  logic             jmp;
  logic [PC_W-1:0]  jmp_addr;
  logic             halt_req;
  logic             resume;
  logic             halted;

  modport master (
    output pc, ir, ir_valid, halted,
    input  ins_in, ir_ack, jmp, jmp_addr, halt_req, resume
  );

  modport slave (
    input  pc, ir, ir_valid, halted,
    output ins_in, ir_ack, jmp, jmp_addr, halt_req, resume
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end of the 4-bit CPU. Drives the PC to the
// instruction memory, captures the combinational memory word into IR and
// hands it to the decoder over a valid/ack handshake. Jumps flush IR;
// halt/resume freeze and restart fetching.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int              PC_W     = 4,
  parameter int              INS_W    = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [INS_W-1:0] ir_q, ir_d;
  logic             valid_q, valid_d;

  logic [PC_W-1:0]  pc_inc;
  logic             accept;
  logic             can_fetch;

  assign pc_inc    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign accept    = valid_q & bus.ir_ack;
  assign can_fetch = ~valid_q | bus.ir_ack;

  // State, PC and instruction register; reset discards any pending IR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  // Next-state decode: jump beats halt beats fetch beats stall in RUN;
  // HALTED only services accepts, jumps and resume, never fetching
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
        if (bus.jmp) begin
          pc_d    = bus.jmp_addr;
          valid_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.jmp) begin
          pc_d    = bus.jmp_addr;
          valid_d = 1'b0;
        end else if (bus.halt_req) begin
          state_d = ST_HALTED;
          if (accept) begin
            valid_d = 1'b0;
          end
        end else if (can_fetch) begin
          ir_d    = bus.ins_in;
          valid_d = 1'b1;
          pc_d    = pc_inc;
        end
      end
      ST_HALTED: begin
        if (accept) begin
          valid_d = 1'b0;
        end
        if (bus.jmp) begin
          pc_d    = bus.jmp_addr;
          valid_d = 1'b0;
        end
        if (bus.resume) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.pc       = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = valid_q;
  assign bus.halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: table of per-cycle stimulus with hand-derived
// expected PC/IR/IR_VALID/HALTED, pushed to a scoreboard queue when driven
// and popped after the clock edge, plus a hand-written async reset sequence.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic clk;
  logic rst;

  fetch_unit_if #(.PC_W(4), .INS_W(9)) bus ();

  fetch_unit #(.PC_W(4), .INS_W(9), .RESET_PC(4'h0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       ack;
    logic       jmp;
    logic [3:0] addr;
    logic       halt;
    logic       resume;
    logic [3:0] pc;
    logic [8:0] ir;
    logic       valid;
    logic       halted;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] pc;
    logic [8:0] ir;
    logic       valid;
    logic       halted;
    string      name;
  } exp_t;

  vec_t vecs_a[$];
  vec_t vecs_b[$];
  exp_t sb[$];

  int checks;
  int errors;

  // Bench ROM: address n returns 1<<n for n<9, otherwise all ones
  function automatic logic [8:0] rom(input logic [3:0] a);
    logic [8:0] one;
    one = 9'h001;
    if (a < 4'd9) return one << a;
    return 9'h1FF;
  endfunction

  assign bus.ins_in = rom(bus.pc);

  // 40 ns period, comfortably above the memory access time
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic ack, input logic jmp, input logic [3:0] addr,
                              input logic halt, input logic resume,
                              input logic [3:0] pc, input logic [8:0] ir,
                              input logic valid, input logic halted, input string name);
    vec_t v;
    v.ack = ack; v.jmp = jmp; v.addr = addr; v.halt = halt; v.resume = resume;
    v.pc = pc; v.ir = ir; v.valid = valid; v.halted = halted; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Pops the oldest expectation and compares it against the DUT outputs
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: actual=empty required=entry");
      return;
    end
    e = sb.pop_front();
    check({e.name, ".pc"},     {5'd0, bus.pc},      {5'd0, e.pc});
    check({e.name, ".ir"},     bus.ir,              e.ir);
    check({e.name, ".valid"},  {8'd0, bus.ir_valid}, {8'd0, e.valid});
    check({e.name, ".halted"}, {8'd0, bus.halted},   {8'd0, e.halted});
  endtask

  // Drives one cycle of inputs, records the expectation, clocks, then checks
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bus.ir_ack   = v.ack;
    bus.jmp      = v.jmp;
    bus.jmp_addr = v.addr;
    bus.halt_req = v.halt;
    bus.resume   = v.resume;
    e.pc = v.pc; e.ir = v.ir; e.valid = v.valid; e.halted = v.halted; e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //          ack jmp addr  halt res  pc     ir      v  h
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd0,  9'h000, 0, 0, "idle"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd1,  9'h001, 1, 0, "fetch0"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd2,  9'h002, 1, 0, "fetch1"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd3,  9'h004, 1, 0, "fetch2"));
    vecs_a.push_back(mk(0, 0, 4'h0, 0, 0, 4'd3,  9'h004, 1, 0, "stall1"));
    vecs_a.push_back(mk(0, 0, 4'h0, 0, 0, 4'd3,  9'h004, 1, 0, "stall2"));
    vecs_a.push_back(mk(0, 0, 4'h0, 0, 0, 4'd3,  9'h004, 1, 0, "stall3"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd4,  9'h008, 1, 0, "unstall"));
    vecs_a.push_back(mk(0, 1, 4'hC, 0, 0, 4'd12, 9'h008, 0, 0, "jmp_flush"));
    vecs_a.push_back(mk(0, 0, 4'h0, 0, 0, 4'd13, 9'h1FF, 1, 0, "after_jmp"));
    vecs_a.push_back(mk(0, 1, 4'hE, 1, 0, 4'd14, 9'h1FF, 0, 0, "jmp_beats_halt"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd15, 9'h1FF, 1, 0, "wrap14"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd0,  9'h1FF, 1, 0, "wrap15"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd1,  9'h001, 1, 0, "wrap0"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd2,  9'h002, 1, 0, "run1"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd3,  9'h004, 1, 0, "run2"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd4,  9'h008, 1, 0, "run3"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd5,  9'h010, 1, 0, "run4"));
    vecs_a.push_back(mk(0, 0, 4'h0, 1, 0, 4'd5,  9'h010, 1, 1, "halt"));
    vecs_a.push_back(mk(0, 0, 4'h0, 1, 0, 4'd5,  9'h010, 1, 1, "halt_hold"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd5,  9'h010, 0, 1, "halt_ack"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd5,  9'h010, 0, 1, "halt_ack_idle"));
    vecs_a.push_back(mk(0, 0, 4'h0, 0, 1, 4'd5,  9'h010, 0, 0, "resume"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd6,  9'h020, 1, 0, "resume_fetch"));
    vecs_a.push_back(mk(0, 0, 4'h0, 1, 0, 4'd6,  9'h020, 1, 1, "halt2"));
    vecs_a.push_back(mk(0, 1, 4'h2, 0, 0, 4'd2,  9'h020, 0, 1, "halt_jmp"));
    vecs_a.push_back(mk(0, 1, 4'h7, 0, 1, 4'd7,  9'h020, 0, 0, "jmp_resume"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd8,  9'h080, 1, 0, "fetch7"));
    vecs_a.push_back(mk(1, 0, 4'h0, 0, 0, 4'd9,  9'h100, 1, 0, "fetch8"));

    vecs_b.push_back(mk(0, 1, 4'h3, 0, 0, 4'd3,  9'h000, 0, 0, "idle_jmp"));
    vecs_b.push_back(mk(1, 0, 4'h0, 0, 0, 4'd4,  9'h008, 1, 0, "post_rst_fetch"));

    rst          = 1'b1;
    bus.ir_ack   = 1'b0;
    bus.jmp      = 1'b0;
    bus.jmp_addr = 4'h0;
    bus.halt_req = 1'b0;
    bus.resume   = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("rst.pc",     {5'd0, bus.pc},       9'h000);
    check("rst.ir",     bus.ir,               9'h000);
    check("rst.valid",  {8'd0, bus.ir_valid}, 9'h000);
    check("rst.halted", {8'd0, bus.halted},   9'h000);
    rst = 1'b0;

    foreach (vecs_a[i]) applyStimulus(vecs_a[i]);

    // Async reset between edges with a valid IR at PC=9
    bus.ir_ack = 1'b0;
    #5;
    rst = 1'b1;
    #1;
    check("arst.pc",     {5'd0, bus.pc},       9'h000);
    check("arst.ir",     bus.ir,               9'h000);
    check("arst.valid",  {8'd0, bus.ir_valid}, 9'h000);
    check("arst.halted", {8'd0, bus.halted},   9'h000);
    #2;
    rst = 1'b0;

    foreach (vecs_b[i]) applyStimulus(vecs_b[i]);

    check("sb_drained", 9'(sb.size()), 9'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
